// File: rtl/booth_mult_core.sv
// booth_mult_core: sequential radix-2 Booth multiplier, one step per CALC cycle
module booth_mult_core #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     switch_A,
  input  logic [WIDTH-1:0]     switch_B,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);
  logic [1:0]       state;
  logic [WIDTH:0]   m, acc, sum;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [CW-1:0]    count;
  always_comb sum = ({q[0], q_1} == 2'b01) ? acc + m : ({q[0], q_1} == 2'b10) ? acc - m : acc;
  assign busy = state == CALC;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      count   <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          m     <= {switch_A[WIDTH-1], switch_A};
          q     <= switch_B;
          acc   <= '0;
          q_1   <= 1'b0;
          count <= '0;
          state <= CALC;
        end
        CALC: begin
          acc   <= {sum[WIDTH], sum[WIDTH:1]};
          q     <= {sum[0], q[WIDTH-1:1]};
          q_1   <= q[0];
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          product <= {acc[WIDTH-1:0], q};
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
